// File: rtl/sparc_mem_ctrl.sv
// Big-endian byte/half/word memory controller answering the CU MFA/MFC handshake.
// Optional macro MEM_ALIGN_CHECK_EN: flag misaligned accesses instead of aligning down.
module sparc_mem_ctrl #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        MFC,
  output logic        MEM_FAULT,
  output logic        BUSY
);

  localparam int AW = ADDR_BITS;
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [AW-1:0]  r_addr;
  logic [31:0]    r_din;
  logic [31:0]    r_dout;
  logic [1:0]     r_size;
  logic           r_rw;
  logic           r_sgn;
  logic           r_mfc;
  logic           r_fault;

  logic [7:0]     ram [0:2**AW-1];

  logic [AW-1:0]  w_a0;
  logic [AW-1:0]  w_a1;
  logic [AW-1:0]  w_a2;
  logic [AW-1:0]  w_a3;
  logic           w_mis;
  logic           w_we;
  logic [31:0]    w_rd;
  logic [7:0]     w_b0;
  logic [7:0]     w_b1;
  logic           w_unused;

  assign w_unused = ^ADDR[31:AW];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = (r_size == 2'b01 && r_addr[0]) ||
                 (r_size[1] && r_addr[1:0] != 2'b00);
  assign w_a0  = r_addr;
`else
  assign w_mis = 1'b0;
  always_comb begin
    w_a0 = r_addr;
    if (r_size == 2'b01)
      w_a0[0] = 1'b0;
    else if (r_size[1])
      w_a0[1:0] = 2'b00;
  end
`endif

  // Byte offsets wrap naturally in the AW-bit adder.
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);

  assign w_b0 = ram[w_a0];
  assign w_b1 = ram[w_a1];

  always_comb begin
    w_rd = {w_b0, w_b1, ram[w_a2], ram[w_a3]};
    case (r_size)
      2'b00:
        w_rd = r_sgn ? {{24{w_b0[7]}}, w_b0}
                     : {24'h0, w_b0};
      2'b01:
        w_rd = r_sgn ? {{16{w_b0[7]}}, w_b0, w_b1}
                     : {16'h0, w_b0, w_b1};
      default: ;
    endcase
  end

  // Reset on the closing edge must also suppress the write.
  assign w_we = (r_state == S_ACCESS) && !r_rw && !w_mis && !Reset;

  always_ff @(posedge Clk) begin
    if (w_we) begin
      case (r_size)
        2'b00: ram[w_a0] <= r_din[7:0];
        2'b01: begin
          ram[w_a0] <= r_din[15:8];
          ram[w_a1] <= r_din[7:0];
        end
        default: begin
          ram[w_a0] <= r_din[31:24];
          ram[w_a1] <= r_din[23:16];
          ram[w_a2] <= r_din[15:8];
          ram[w_a3] <= r_din[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_din   <= 32'h0;
      r_dout  <= 32'h0;
      r_size  <= 2'b00;
      r_rw    <= 1'b0;
      r_sgn   <= 1'b0;
      r_mfc   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MFA) begin
            r_addr <= ADDR[AW-1:0];
            r_din  <= DATA_IN;
            r_rw   <= RW;
            r_size <= SIZE;
            r_sgn  <= SIGNED;
            r_cnt  <= CNT_INIT;
            r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= S_ACCESS;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_ACCESS: begin
          r_mfc   <= 1'b1;
          r_fault <= w_mis;
          if (r_rw && !w_mis)
            r_dout <= w_rd;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!MFA) begin
            r_mfc   <= 1'b0;
            r_fault <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DATA_OUT  = r_dout;
  assign MFC       = r_mfc;
  assign MEM_FAULT = r_fault;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// Directed bench for sparc_mem_ctrl (default WAIT_STATES=2).
module tb_sparc_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MFA = 1'b0;
  logic        RW = 1'b1;
  logic [1:0]  SIZE = 2'b10;
  logic        SIGNED = 1'b0;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] DATA_IN = 32'h0;
  logic [31:0] DATA_OUT;
  logic        MFC;
  logic        MEM_FAULT;
  logic        BUSY;

  int tests = 0;
  int fails = 0;

  sparc_mem_ctrl dut (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .RW(RW),
    .SIZE(SIZE), .SIGNED(SIGNED), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MFC(MFC),
    .MEM_FAULT(MEM_FAULT), .BUSY(BUSY)
  );

  always #5 Clk = ~Clk;

  // Issue a request and wait for MFC; lat = edges after E0 (99 on timeout).
  task automatic do_access(input logic rw, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] d, input logic scramble,
                           output logic [31:0] dout, output logic flt,
                           output int lat);
    int n;
    @(negedge Clk);
    MFA = 1'b1; RW = rw; SIZE = sz; SIGNED = sg;
    ADDR = a; DATA_IN = d;
    @(posedge Clk); #1;
    if (scramble) begin
      ADDR = a ^ 32'h4; DATA_IN = ~d; RW = ~rw;
    end
    n = 0;
    lat = 99;
    while (n < 40) begin
      @(posedge Clk); #1;
      n++;
      if (MFC) begin
        lat = n;
        break;
      end
    end
    dout = DATA_OUT;
    flt = MEM_FAULT;
  endtask

  task automatic release_mfa();
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    #1;
    tests++;
    if (MFC !== 1'b0 || BUSY !== 1'b0 || MEM_FAULT !== 1'b0 ||
        DATA_OUT !== 32'h0) begin
      fails++;
      $display("FAIL reset: MFC=%b BUSY=%b FLT=%b DO=%h want 0 0 0 0",
               MFC, BUSY, MEM_FAULT, DATA_OUT);
    end
    dut.ram[0] = 8'h9C; dut.ram[1] = 8'h04;
    dut.ram[2] = 8'h40; dut.ram[3] = 8'h12;
    dut.ram[4] = 8'h11; dut.ram[5] = 8'h22;
    dut.ram[6] = 8'h33; dut.ram[7] = 8'h44;
    dut.ram[8] = 8'hA1; dut.ram[9] = 8'hB2;
    dut.ram[10] = 8'hC3; dut.ram[11] = 8'hD4;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_word_read();
    logic [31:0] d; logic f; int l;
    do_access(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, d, f, l);
    tests++;
    if (l !== 3) begin
      fails++;
      $display("FAIL word_latency: got %0d want 3", l);
    end
    tests++;
    if (d !== 32'h9C044012 || f !== 1'b0) begin
      fails++;
      $display("FAIL word_read: got %h/%b want 9c044012/0", d, f);
    end
    tests++;
    if (BUSY !== 1'b1) begin
      fails++;
      $display("FAIL busy_done: got %b want 1", BUSY);
    end
    release_mfa();
    tests++;
    if (MFC !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL word_release: MFC=%b BUSY=%b want 0 0", MFC, BUSY);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] d; logic f; int l;
    logic [31:0] exp_v [4] = '{32'hFFFFFF9C, 32'h0000009C,
                                32'h00004012, 32'hFFFF9C04};
    logic [1:0]  sz_v  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad_v  [4] = '{32'h0, 32'h0, 32'h2, 32'h0};
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, sz_v[i], sg_v[i], ad_v[i], 32'h0, 1'b0, d, f, l);
      tests++;
      if (d !== exp_v[i] || l !== 3) begin
        fails++;
        $display("FAIL narrow_read%0d: got %h lat %0d want %h lat 3",
                 i, d, l, exp_v[i]);
      end
      release_mfa();
    end
  endtask

  task automatic test_half_write();
    logic [31:0] d; logic f; int l;
    do_access(1'b0, 2'b01, 1'b0, 32'h6, 32'hDEADBEEF, 1'b0, d, f, l);
    tests++;
    if (d !== 32'hFFFF9C04 || l !== 3) begin
      fails++;
      $display("FAIL write_keeps_dout: got %h lat %0d want ffff9c04 lat 3",
               d, l);
    end
    release_mfa();
    do_access(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, d, f, l);
    tests++;
    if (d !== 32'h1122BEEF) begin
      fails++;
      $display("FAIL half_write: got %h want 1122beef", d);
    end
    release_mfa();
  endtask

  task automatic test_hold();
    logic [31:0] d; logic f; int l; int low;
    do_access(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, d, f, l);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (MFC !== 1'b1) low++;
    end
    tests++;
    if (low != 0) begin
      fails++;
      $display("FAIL hold_mfc: dropped %0d times want 0", low);
    end
    release_mfa();
    tests++;
    if (MFC !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: MFC=%b BUSY=%b want 0 0", MFC, BUSY);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic f; int l;
    @(negedge Clk);
    MFA = 1'b1; RW = 1'b0; SIZE = 2'b10;
    ADDR = 32'h8; DATA_IN = 32'hCAFEF00D;
    @(posedge Clk); #1;
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    tests++;
    if (MFC !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: MFC=%b BUSY=%b want 0 0", MFC, BUSY);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    tests++;
    if ({dut.ram[8], dut.ram[9], dut.ram[10], dut.ram[11]}
        !== 32'hA1B2C3D4) begin
      fails++;
      $display("FAIL reset_ram: got %h want a1b2c3d4",
               {dut.ram[8], dut.ram[9], dut.ram[10], dut.ram[11]});
    end
    do_access(1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, d, f, l);
    tests++;
    if (d !== 32'hA1B2C3D4) begin
      fails++;
      $display("FAIL reset_readback: got %h want a1b2c3d4", d);
    end
    release_mfa();
  endtask

  task automatic test_latch_and_high_addr();
    logic [31:0] d; logic f; int l;
    do_access(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h0, 1'b1, d, f, l);
    tests++;
    if (d !== 32'h9C044012 || l !== 3) begin
      fails++;
      $display("FAIL latch_high: got %h lat %0d want 9c044012 lat 3",
               d, l);
    end
    release_mfa();
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic f; int l;
    logic [31:0] bytes47;
    do_access(1'b0, 2'b10, 1'b0, 32'h5, 32'h55667788, 1'b0, d, f, l);
    bytes47 = {dut.ram[4], dut.ram[5], dut.ram[6], dut.ram[7]};
`ifdef MEM_ALIGN_CHECK_EN
    tests++;
    if (f !== 1'b1 || l !== 3) begin
      fails++;
      $display("FAIL mis_fault: got %b lat %0d want 1 lat 3", f, l);
    end
    tests++;
    if (bytes47 !== 32'h1122BEEF || d !== 32'h9C044012) begin
      fails++;
      $display("FAIL mis_nowrite: ram %h dout %h want 1122beef 9c044012",
               bytes47, d);
    end
`else
    tests++;
    if (f !== 1'b0 || l !== 3) begin
      fails++;
      $display("FAIL mis_fault: got %b lat %0d want 0 lat 3", f, l);
    end
    tests++;
    if (bytes47 !== 32'h55667788) begin
      fails++;
      $display("FAIL mis_align: ram %h want 55667788", bytes47);
    end
`endif
    release_mfa();
    tests++;
    if (MEM_FAULT !== 1'b0 || MFC !== 1'b0) begin
      fails++;
      $display("FAIL mis_clear: FLT=%b MFC=%b want 0 0", MEM_FAULT, MFC);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_half();
    test_half_write();
    test_hold();
    test_reset_mid();
    test_latch_and_high_addr();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
